// File: rtl/laser_pkg.sv
// Shared constants for the laser blocks: controller state encoding and
// default shot timing.
package laser_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIRE  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_ACCUM = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int LASER_TIMEOUT_DEF   = 60000;
    localparam int LASER_PULSE_LEN_DEF = 1;

endpackage

// File: rtl/laser_rangefinder_avg_if.sv
// Front-end / display side signals of the rangefinder: request and echo in,
// laser drive, distance and status out.
interface laser_rangefinder_avg_if #(
    parameter int W = 16
);
    logic         B;
    logic         S;
    logic         L;
    logic [W-1:0] D;
    logic         Valid;
    logic         Err;
    logic         Busy;

    modport master (output B, output S, input L, input D, input Valid, input Err, input Busy);
    modport slave  (input B, input S, output L, output D, output Valid, output Err, output Busy);
endinterface

// File: rtl/laser_rangefinder_avg_tof_counter.sv
// Per-shot time-of-flight counter with synchronous clear, count enable and a
// timeout flag.
module tof_counter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 60000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_timeout
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // >= rather than == so an out-of-range pulse length cannot wrap past the limit
    assign at_timeout = (cnt >= W'(TIMEOUT));

endmodule

// File: rtl/laser_rangefinder_avg.sv
// Multi-shot laser time-of-flight rangefinder: fires 2^SHOTS pulses per request,
// sums the round-trip counts and reports the averaged one-way distance.
module laser_rangefinder_avg
    import laser_pkg::*;
#(
    parameter int W         = 16,
    parameter int SHOTS     = 2,
    parameter int PULSE_LEN = LASER_PULSE_LEN_DEF,
    parameter int TIMEOUT   = LASER_TIMEOUT_DEF
) (
    input logic                    Clk,
    input logic                    Rst,
    laser_rangefinder_avg_if.slave bus
);

    localparam int SCW = (SHOTS > 0) ? SHOTS : 1;
    localparam int PCW = $clog2(PULSE_LEN + 1);
    localparam logic [SCW-1:0] SHOT_LAST  = SCW'((1 << SHOTS) - 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_LEN - 1);

    logic [2:0]         state, state_nxt;
    logic [W+SHOTS-1:0] acc;
    logic [SCW-1:0]     shot_ctr;
    logic [PCW-1:0]     pulse_ctr;
    logic [W-1:0]       cnt;
    logic               at_timeout;
    logic               cnt_clr;
    logic               cnt_en;

    tof_counter #(.W(W), .TIMEOUT(TIMEOUT)) u_tof (
        .clk        (Clk),
        .rst        (Rst),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .cnt        (cnt),
        .at_timeout (at_timeout)
    );

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: if (bus.B) begin
                state_nxt = ST_FIRE;
                cnt_clr   = 1'b1;
            end
            ST_FIRE: begin
                cnt_en = 1'b1;
                if (pulse_ctr == PULSE_LAST)
                    state_nxt = ST_WAIT;
            end
            // echo has priority over timeout on the same cycle
            ST_WAIT: begin
                if (bus.S)
                    state_nxt = ST_ACCUM;
                else if (at_timeout)
                    state_nxt = ST_IDLE;
                else
                    cnt_en = 1'b1;
            end
            ST_ACCUM: begin
                if (shot_ctr == SHOT_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_FIRE;
                    cnt_clr   = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            shot_ctr  <= '0;
            pulse_ctr <= '0;
            bus.L     <= 1'b0;
            bus.D     <= '0;
            bus.Valid <= 1'b0;
            bus.Err   <= 1'b0;
            bus.Busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            // outputs follow the next state so they line up with the state register
            bus.L     <= (state_nxt == ST_FIRE);
            bus.Busy  <= (state_nxt != ST_IDLE);
            bus.Valid <= (state == ST_DONE);
            bus.Err   <= (state == ST_WAIT) && !bus.S && at_timeout;
            case (state)
                ST_IDLE: if (bus.B) begin
                    acc       <= '0;
                    shot_ctr  <= '0;
                    pulse_ctr <= '0;
                end
                ST_FIRE: pulse_ctr <= pulse_ctr + 1'b1;
                ST_WAIT: if (bus.S) acc <= acc + (W+SHOTS)'(cnt);
                ST_ACCUM: if (shot_ctr != SHOT_LAST) begin
                    shot_ctr  <= shot_ctr + 1'b1;
                    pulse_ctr <= '0;
                end
                ST_DONE: bus.D <= W'(acc >> (SHOTS + 1));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_rangefinder_avg.sv
// Randomised bench for laser_rangefinder_avg: two configurations, each burst's
// timeline and averaged distance predicted from the shot schedule chosen here.
module tb_laser_rangefinder_avg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic b_drv, s_drv;
    int   sel;
    int   total, bad;

    int          cfg_shots [2] = '{0, 2};
    int          cfg_p     [2] = '{1, 3};
    int          cfg_t     [2] = '{20, 40};
    logic [15:0] d_model   [2];
    int          jw        [4];

    laser_rangefinder_avg_if #(.W(16)) if0 ();
    laser_rangefinder_avg_if #(.W(16)) if1 ();

    assign if0.B = b_drv && (sel == 0);
    assign if0.S = s_drv && (sel == 0);
    assign if1.B = b_drv && (sel == 1);
    assign if1.S = s_drv && (sel == 1);

    laser_rangefinder_avg #(.W(16), .SHOTS(0), .PULSE_LEN(1), .TIMEOUT(20)) dut0 (
        .Clk (clk), .Rst (rst), .bus (if0)
    );
    laser_rangefinder_avg #(.W(16), .SHOTS(2), .PULSE_LEN(3), .TIMEOUT(40)) dut1 (
        .Clk (clk), .Rst (rst), .bus (if1)
    );

    logic        o_l, o_busy, o_valid, o_err;
    logic [15:0] o_d;
    assign o_l     = sel ? if1.L     : if0.L;
    assign o_busy  = sel ? if1.Busy  : if0.Busy;
    assign o_valid = sel ? if1.Valid : if0.Valid;
    assign o_err   = sel ? if1.Err   : if0.Err;
    assign o_d     = sel ? if1.D     : if0.D;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d expected=%0d t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    task automatic chk_idle();
        chk("L", o_l, 0);
        chk("Busy", o_busy, 0);
        chk("Valid", o_valid, 0);
        chk("Err", o_err, 0);
        chk("D", o_d, d_model[sel]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk_idle();
            b_drv = 1'b0;
            s_drv = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic go();
        @(negedge clk);
        chk_idle();
        b_drv = 1'b1;
        s_drv = 1'($urandom_range(0, 1));
    endtask

    function automatic int rnd_wait();
        int mx = cfg_t[sel] - cfg_p[sel] + 1;
        int r  = int'($urandom_range(0, 5));
        if (r == 0) return 1;
        if (r == 1) return mx;
        return int'($urandom_range(1, mx));
    endfunction

    // Cycle 0 is the IDLE cycle whose B was just driven high. Shot i: PULSE_LEN fire
    // cycles, jw[i] wait cycles with the echo on the last, one accumulate cycle.
    task automatic burst(input int to_shot, input int rst_shot, input bit chain);
        bit eL [256], eBusy [256], eV [256], eE [256];
        int sdrv [256];
        int n = 1 << cfg_shots[sel];
        int p = cfg_p[sel];
        int tt = 1, sum = 0, fin = 0, rst_cyc = -1, j;
        bit ok = 1'b1, stop = 1'b0;
        for (int k = 0; k < 256; k++) begin
            eL[k] = 0; eBusy[k] = 0; eV[k] = 0; eE[k] = 0; sdrv[k] = 0;
        end
        for (int i = 0; i < n && !stop; i++) begin
            j = (i == to_shot) ? cfg_t[sel] - p + 1 : jw[i];
            for (int k = 0; k < p; k++) begin
                eL[tt+k] = 1; eBusy[tt+k] = 1; sdrv[tt+k] = 2;
            end
            for (int k = 0; k < j; k++) begin
                eBusy[tt+p+k] = 1; sdrv[tt+p+k] = 0;
            end
            if (i == rst_shot) begin
                rst_cyc = tt + p + j / 2;
                fin = rst_cyc + 1; ok = 1'b0; stop = 1'b1;
            end else if (i == to_shot) begin
                fin = tt + p + j; eE[fin] = 1; ok = 1'b0; stop = 1'b1;
            end else begin
                sdrv[tt+p+j-1] = 1;
                sum += p + j - 1;
                eBusy[tt+p+j] = 1; sdrv[tt+p+j] = 2;
                tt += p + j + 1;
            end
        end
        if (ok) begin
            eBusy[tt] = 1; sdrv[tt] = 2;
            fin = tt + 1; eV[fin] = 1;
        end
        eBusy[fin] = 0; eL[fin] = 0; sdrv[fin] = 2;
        for (int t = 1; t <= fin; t++) begin
            @(negedge clk);
            if (t == fin && rst_cyc >= 0) begin
                d_model[0] = '0; d_model[1] = '0; rst = 1'b0;
            end
            if (t == fin && ok)
                d_model[sel] = 16'(sum >> (cfg_shots[sel] + 1));
            chk("L", o_l, eL[t]);
            chk("Busy", o_busy, eBusy[t]);
            chk("Valid", o_valid, eV[t]);
            chk("Err", o_err, eE[t]);
            chk("D", o_d, d_model[sel]);
            if (t == rst_cyc) rst = 1'b1;
            s_drv = (sdrv[t] == 2) ? 1'($urandom_range(0, 1)) : sdrv[t][0];
            b_drv = (t < fin) ? 1'($urandom_range(0, 1)) : (chain && rst_cyc < 0);
        end
    endtask

    task automatic rand_bursts(input int n);
        bit armed = 1'b0, chain;
        int to;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 4; i++) jw[i] = rnd_wait();
            to = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, (1 << cfg_shots[sel]) - 1)) : -1;
            chain = (b < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!armed) begin
                idle(int'($urandom_range(0, 2)));
                go();
            end
            burst(to, -1, chain);
            armed = chain;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; b_drv = 1'b0; s_drv = 1'b0; sel = 0;
        d_model[0] = '0; d_model[1] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0 chk_idle();
        end
        sel = 0;
        rst = 1'b0;

        // single shot: echo on 10th wait cycle -> Cnt 10, D 5
        idle(2);
        jw[0] = 10; go(); burst(-1, -1, 1'b0);
        chk("D_single", o_d, 16'd5);
        // timeout leaves D untouched
        go(); burst(0, -1, 1'b0);
        chk("D_keep", o_d, 16'd5);
        // echo on the timeout cycle is captured
        jw[0] = 20; go(); burst(-1, -1, 1'b0);
        chk("D_edge", o_d, 16'd10);
        jw[0] = 1; go(); burst(-1, -1, 1'b0);
        // B held high: back-to-back bursts
        jw[0] = rnd_wait(); go(); burst(-1, -1, 1'b1);
        jw[0] = rnd_wait(); burst(-1, -1, 1'b1);
        jw[0] = rnd_wait(); burst(-1, -1, 1'b0);
        rand_bursts(12);

        sel = 1;
        idle(2);
        // four shots with Cnt 10,12,14,16 -> 52 >> 3 = 6
        jw = '{8, 10, 12, 14}; go(); burst(-1, -1, 1'b0);
        chk("D_avg4", o_d, 16'd6);
        for (int i = 0; i < 4; i++) jw[i] = rnd_wait();
        go(); burst(2, -1, 1'b0);
        chk("D_keep4", o_d, 16'd6);
        // reset mid-burst, then a clean burst: Cnt 7 x4 -> 28 >> 3 = 3
        for (int i = 0; i < 4; i++) jw[i] = rnd_wait();
        go(); burst(-1, 2, 1'b0);
        chk("D_rst", o_d, 16'd0);
        jw = '{5, 5, 5, 5}; go(); burst(-1, -1, 1'b0);
        chk("D_after_rst", o_d, 16'd3);
        rand_bursts(12);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
